alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 32x32->64 shift-and-add multiplier that time-shares the core's single 32-bit ALU instead of instantiating its own adder.
- Sits beside the execute stage: takes operands over a start/ready handshake, requests the ALU through an alu_req/alu_gnt arbitration pair, drives ALU operands/opcode, consumes the ALU result.
- Returns a 64-bit product with a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/ALU width; only 32 is supported.
- ITER_W, 6, iteration-counter width; must hold XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request
- ready  out  1  block can accept start (high only in IDLE)
- op_a  in  32  multiplicand
- op_b  in  32  multiplier
- busy  out  1  operation in progress (accept through DONE)
- done  out  1  one-cycle pulse: result valid
- result_lo  out  32  product bits [31:0]
- result_hi  out  32  product bits [63:32]
- alu_req  out  1  ALU wanted this cycle
- alu_gnt  in  1  ALU granted to this block this cycle
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  4  ALU opcode
- alu_result  in  32  ALU result, combinational, same cycle

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- During reset:
  - State is IDLE.
  - busy=0, done=0, alu_req=0.
  - result_lo/result_hi=0, alu_a/alu_b=0, alu_op=ADD (4'b0010).
  - ready=1 (decoded from IDLE).
- States: IDLE -> MUL -> DONE -> IDLE.
- IDLE:
  - Accept when start && ready; latch M=op_a, hi=0, lo=op_b, cnt=0.
  - Next state MUL.
  - start while not ready is ignored.
- MUL:
  - alu_req=1.
  - alu_op=ADD, alu_a=hi, alu_b = lo[0] ? M : 0.
  - An iteration executes only in a cycle with alu_gnt=1:
    - sum=alu_result.
    - carry = lo[0] && (alu_result < hi), unsigned compare.
    - {hi,lo} <= {carry,sum,lo} >> 1.
    - cnt++.
  - alu_gnt=0: all state held; the stall is unbounded.
  - After the iteration with cnt==31, next state DONE.
- DONE:
  - alu_req=0, done=1 for exactly one cycle.
  - result_lo=lo, result_hi=hi. Results hold until the next accept.
  - Next state IDLE.
- Outside MUL: alu_req=0, alu_a=alu_b=0, alu_op=ADD. alu_gnt is ignored.
- Latency with continuous grant:
  - Accept at edge T.
  - MUL occupies cycles T+1..T+32.
  - done high in cycle T+33.
  - ready high again in T+34.
- Boundary conditions:
  - Zero operands still take 32 iterations.
  - Reset asserted mid-operation aborts immediately: alu_req drops asynchronously, no done, prior results cleared.
  - alu_gnt toggling every cycle doubles latency; the result is unchanged.

Optional Feature:
- Macro MUL_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), latched at accept.
  - If is_signed, extra ALU-sequenced states run, each using one granted ALU cycle:
    - NEG_A before MUL: if op_a[31], M = 0 - op_a via alu_op=SUB (4'b0110).
    - NEG_B before MUL: if op_b[31], lo = 0 - op_b via SUB.
    - NEG_LO and NEG_HI after MUL, only if signs differ:
      - NEG_LO: lo = 0 - lo via SUB.
      - NEG_HI: hi = ~hi + (lo_pre==0) via ADD.
  - A state whose condition is false is skipped with zero cycles.
  - Latency is 33 + (number of executed NEG states) with continuous grant.
- Undefined: port is absent; behaviour is unsigned only.

Decomposition:
- Shared package alu_defs holds:
  - ALU opcode constants: AND=4'b0000, OR=4'b0001, ADD=4'b0010, SUB=4'b0110, SRL=4'b1010.
  - XLEN.
  - State encoding for this block.
  - The ALU, decoder and this block all use these.
- One sub-module: mul_step, combinational.
  - Inputs: hi, lo, M, alu_result.
  - Outputs: alu_b select, carry, next {hi,lo}.
  - Reused by a future divider sequencer.
- FSM and counter stay in alu_mul_seq.

Test Plan:
- Reset then op_a=6, op_b=7, start, alu_gnt tied 1 -> done in cycle T+33; result_hi=0, result_lo=42; ready returns T+34.
- op_a=op_b=0xFFFFFFFF, gnt=1 -> result_hi=0xFFFFFFFE, result_lo=0x00000001 (carry path exercised).
- op_a=0x12345678, op_b=0x9ABCDEF0, alu_gnt random 50% -> product 0x0B00EA4E_242D2080; done only after exactly 32 granted MUL cycles; alu_op==ADD throughout.
- Start asserted during busy with different operands -> ignored; first result correct; no second done.
- rst_n pulsed low at MUL iteration 10 -> alu_req/busy/done fall immediately, ready=1; a new 3x5 operation then returns 15.
- (MUL_SIGNED_EN) is_signed=1, op_a=0xFFFFFFFD (-3), op_b=5 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1 (-15); NEG_A, NEG_LO and NEG_HI executed, NEG_B skipped; done at T+36.

Source files
------------

// File: rtl/alu_defs.sv
// Shared ALU definitions: opcodes, datapath width and the multiply sequencer state encoding.
package alu_defs;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ITER_W = 6;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NEG_A  = 3'd1,
        ST_NEG_B  = 3'd2,
        ST_MUL    = 3'd3,
        ST_NEG_LO = 3'd4,
        ST_NEG_HI = 3'd5,
        ST_DONE   = 3'd6
    } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-and-add step: folds the shared-ALU sum into {hi,lo} and selects the next operand B.
module mul_step
    import alu_defs::*;
(
    input  logic [XLEN-1:0]   hi,
    input  logic [XLEN-1:0]   lo,
    input  logic [XLEN-1:0]   m,
    input  logic [XLEN-1:0]   alu_result,
    output logic              carry,
    output logic [2*XLEN-2:0] shr_nxt,
    output logic [XLEN-1:0]   alu_b_nxt
);

    // The ALU is only 32 bits wide, so the 33rd sum bit is recovered from wrap-around.
    assign carry     = lo[0] && (alu_result < hi);
    assign shr_nxt   = {alu_result, lo[XLEN-1:1]};
    assign alu_b_nxt = lo[1] ? m : '0;

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential 32x32->64 multiplier that borrows the core's shared ALU for each add.
// Optional signed support (is_signed port, NEG_* states) is built when MUL_SIGNED_EN is defined.
module alu_mul_seq
    import alu_defs::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
`ifdef MUL_SIGNED_EN
    input  logic            is_signed,
`endif
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result_lo,
    output logic [XLEN-1:0] result_hi,
    output logic            alu_req,
    input  logic            alu_gnt,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result
);

    mul_state_e        state_q, state_d;
    logic [XLEN-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              neg_res_q, neg_res_d, lo_zero_q, lo_zero_d;
    logic              ready_q, ready_d, busy_q, busy_d, done_q, done_d;
    logic [XLEN-1:0]   res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic              alu_req_q, alu_req_d;
    logic [XLEN-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]        alu_op_q, alu_op_d;

    logic              step_carry;
    logic [2*XLEN-2:0] step_shr;
    logic [XLEN-1:0]   step_b_nxt;
    logic              neg_a_c, neg_b_c, neg_res_c;

`ifdef MUL_SIGNED_EN
    assign neg_a_c   = is_signed & op_a[XLEN-1];
    assign neg_b_c   = is_signed & op_b[XLEN-1];
    assign neg_res_c = is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
`else
    assign neg_a_c   = 1'b0;
    assign neg_b_c   = 1'b0;
    assign neg_res_c = 1'b0;
`endif

    mul_step u_step (
        .hi         (hi_q),
        .lo         (lo_q),
        .m          (m_q),
        .alu_result (alu_result),
        .carry      (step_carry),
        .shr_nxt    (step_shr),
        .alu_b_nxt  (step_b_nxt)
    );

    // Next-state and datapath; each ALU-using state advances only on a granted cycle.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        lo_zero_d = lo_zero_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d       = op_a;
                    hi_d      = '0;
                    lo_d      = op_b;
                    cnt_d     = '0;
                    neg_res_d = neg_res_c;
                    if (neg_a_c)      state_d = ST_NEG_A;
                    else if (neg_b_c) state_d = ST_NEG_B;
                    else              state_d = ST_MUL;
                end
            end
            ST_NEG_A: begin
                if (alu_gnt) begin
                    m_d     = alu_result;
                    state_d = lo_q[XLEN-1] ? ST_NEG_B : ST_MUL;
                end
            end
            ST_NEG_B: begin
                if (alu_gnt) begin
                    lo_d    = alu_result;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                if (alu_gnt) begin
                    {hi_d, lo_d} = {step_carry, step_shr};
                    cnt_d        = cnt_q + ITER_W'(1);
                    if (cnt_q == ITER_W'(XLEN - 1))
                        state_d = neg_res_q ? ST_NEG_LO : ST_DONE;
                end
            end
            ST_NEG_LO: begin
                if (alu_gnt) begin
                    lo_d      = alu_result;
                    lo_zero_d = (lo_q == '0);
                    state_d   = ST_NEG_HI;
                end
            end
            ST_NEG_HI: begin
                if (alu_gnt) begin
                    hi_d    = alu_result;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_DONE) begin
            res_lo_d = lo_d;
            res_hi_d = hi_d;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_comb begin
        ready_d   = (state_d == ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        alu_req_d = 1'b0;
        alu_op_d  = ALU_ADD;
        alu_a_d   = '0;
        alu_b_d   = '0;

        unique case (state_d)
            ST_NEG_A: begin
                alu_req_d = 1'b1;
                alu_op_d  = ALU_SUB;
                alu_b_d   = m_d;
            end
            ST_NEG_B, ST_NEG_LO: begin
                alu_req_d = 1'b1;
                alu_op_d  = ALU_SUB;
                alu_b_d   = lo_d;
            end
            ST_MUL: begin
                alu_req_d = 1'b1;
                alu_a_d   = hi_d;
                alu_b_d   = (state_q == ST_MUL && alu_gnt) ? step_b_nxt
                                                           : (lo_d[0] ? m_d : '0);
            end
            ST_NEG_HI: begin
                alu_req_d = 1'b1;
                alu_a_d   = ~hi_d;
                alu_b_d   = XLEN'(lo_zero_d);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            lo_zero_q <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            alu_req_q <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= ALU_ADD;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            lo_zero_q <= lo_zero_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            alu_req_q <= alu_req_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign alu_req   = alu_req_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: shared-ALU model, operand table, random products, corner sequences.
module tb_alu_mul_seq;
    import alu_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ready;
    logic [31:0] op_a, op_b;
`ifdef MUL_SIGNED_EN
    logic        is_signed = 1'b0;
`endif
    logic        busy, done;
    logic [31:0] result_lo, result_hi;
    logic        alu_req, alu_gnt;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mul_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ready      (ready),
        .op_a       (op_a),
        .op_b       (op_b),
`ifdef MUL_SIGNED_EN
        .is_signed  (is_signed),
`endif
        .busy       (busy),
        .done       (done),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
    );

    // The core's shared ALU, purely combinational.
    always_comb begin
        case (alu_op)
            ALU_AND: alu_result = alu_a & alu_b;
            ALU_OR:  alu_result = alu_a | alu_b;
            ALU_ADD: alu_result = alu_a + alu_b;
            ALU_SUB: alu_result = alu_a - alu_b;
            ALU_SRL: alu_result = alu_a >> alu_b[4:0];
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // gnt_mode: 0 = always granted, 1 = random 50%, 2 = toggling starting low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int gnt_mode,
                          input bit poke, output logic [63:0] prod, output int edges,
                          output int grants, output int bad_op, output bit seen_done);
        int wait_cnt;
        edges = 0; grants = 0; bad_op = 0; seen_done = 1'b0; wait_cnt = 0;
        alu_gnt = 1'b1;
        while (!ready && wait_cnt < 200) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!done && edges < 400) begin
            case (gnt_mode)
                0:       alu_gnt = 1'b1;
                1:       alu_gnt = 1'($urandom_range(0, 1));
                default: alu_gnt = 1'(edges % 2);
            endcase
            if (poke) begin
                start = 1'b1;
                op_a  = $urandom;
                op_b  = $urandom;
            end
            if (alu_req && alu_op !== ALU_ADD) bad_op++;
            if (alu_req && alu_gnt) grants++;
            @(posedge clk); #1;
            edges++;
        end
        seen_done = done;
        prod = {result_hi, result_lo};
        @(posedge clk); #1;
        start = 1'b0;
        alu_gnt = 1'b1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t        vecs[7];
    logic [63:0] prod;
    int          edges, grants, bad_op, extra_done;
    bit          seen;

    initial begin
        vecs[0] = '{32'd6,        32'd7,        64'd42};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080};
        vecs[3] = '{32'd0,        32'd0,        64'd0};
        vecs[4] = '{32'd0,        32'hFFFFFFFF, 64'd0};
        vecs[5] = '{32'd1,        32'h80000000, 64'h00000000_80000000};
        vecs[6] = '{32'h80000000, 32'd2,        64'h00000001_00000000};

        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; alu_gnt = 1'b0;
        #23;
        check("rst_ready",   64'(ready),   64'd1);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_alu_req", 64'(alu_req), 64'd0);
        check("rst_result",  {result_hi, result_lo}, 64'd0);
        check("rst_alu_ab",  {alu_a, alu_b}, 64'd0);
        check("rst_alu_op",  64'(alu_op),  64'(ALU_ADD));
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed operand table with continuous grant: product, 32-edge latency, ready right after.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, 1'b0, prod, edges, grants, bad_op, seen);
            check($sformatf("tbl%0d_done", i),  64'(seen),  64'd1);
            check($sformatf("tbl%0d_prod", i),  prod,       vecs[i].exp);
            check($sformatf("tbl%0d_lat", i),   64'(edges), 64'd32);
            check($sformatf("tbl%0d_ready", i), 64'(ready), 64'd1);
            check($sformatf("tbl%0d_pulse", i), 64'(done),  64'd0);
        end

        // Spec vector under random 50% grant: exactly 32 granted cycles, ADD only.
        run_op(32'h12345678, 32'h9ABCDEF0, 1, 1'b0, prod, edges, grants, bad_op, seen);
        check("rnd_gnt_done",   64'(seen),   64'd1);
        check("rnd_gnt_prod",   prod,        64'h0B00EA4E_242D2080);
        check("rnd_gnt_grants", 64'(grants), 64'd32);
        check("rnd_gnt_op",     64'(bad_op), 64'd0);

        // Random operands against the arithmetic product.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 4 == 0) rb = 32'hFFFFFFFF;
            run_op(ra, rb, 1, 1'b0, prod, edges, grants, bad_op, seen);
            check($sformatf("rnd%0d_prod", i),   prod, {32'h0, ra} * {32'h0, rb});
            check($sformatf("rnd%0d_grants", i), 64'(grants), 64'd32);
            check($sformatf("rnd%0d_op", i),     64'(bad_op), 64'd0);
        end

        // Toggling grant doubles latency, product unchanged.
        run_op(32'hDEADBEEF, 32'h0000CAFE, 2, 1'b0, prod, edges, grants, bad_op, seen);
        check("tog_prod", prod, 64'hDEADBEEF * 64'h0000CAFE);
        check("tog_lat",  64'(edges), 64'd64);

        // Start held during busy with other operands: ignored, single done.
        run_op(32'd1000, 32'd3000, 0, 1'b1, prod, edges, grants, bad_op, seen);
        check("poke_prod", prod, 64'd3000000);
        check("poke_lat",  64'(edges), 64'd32);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        check("poke_no_second_done", 64'(extra_done), 64'd0);
        check("poke_idle_ready",     64'(ready),      64'd1);

        // Asynchronous reset around iteration 10 aborts and clears results.
        op_a = 32'h12345678; op_b = 32'd3; alu_gnt = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_alu_req", 64'(alu_req), 64'd0);
        check("abort_busy",    64'(busy),    64'd0);
        check("abort_done",    64'(done),    64'd0);
        check("abort_ready",   64'(ready),   64'd1);
        check("abort_result",  {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd3, 32'd5, 0, 1'b0, prod, edges, grants, bad_op, seen);
        check("after_abort_prod", prod, 64'd15);
        check("after_abort_lat",  64'(edges), 64'd32);

`ifdef MUL_SIGNED_EN
        // Signed mode: two's complement product, one extra edge per executed NEG state.
        is_signed = 1'b1;
        run_op(32'hFFFFFFFD, 32'd5, 0, 1'b0, prod, edges, grants, bad_op, seen);
        check("sgn_prod", prod, 64'hFFFFFFFF_FFFFFFF1);
        check("sgn_lat",  64'(edges), 64'd35);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] sa, sb;
            int          nneg;
            sa = $urandom;
            sb = $urandom;
            nneg = int'(sa[31]) + int'(sb[31]) + 2 * int'(sa[31] ^ sb[31]);
            run_op(sa, sb, 0, 1'b0, prod, edges, grants, bad_op, seen);
            check($sformatf("sgn%0d_prod", i), prod,
                  64'(longint'($signed(sa)) * longint'($signed(sb))));
            check($sformatf("sgn%0d_lat", i), 64'(edges), 64'(32 + nneg));
        end
        is_signed = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
